// File: rtl/video_shifter.sv
// Video shifter: serialises VRAM bytes into 2-bit pixels LSB-first, maps them through a
// 4-entry palette to 8-bit RGB. Optional macro VIDEO_SHIFTER_TESTPAT_EN adds a column-bar test pattern.
module video_shifter #(
  parameter logic [7:0] BLANK_LEVEL = 8'h00,
  parameter logic [7:0] HI_LEVEL    = 8'hFF,
  parameter logic [7:0] MID_LEVEL   = 8'hAA,
  parameter logic [7:0] DIM_LEVEL   = 8'h55
) (
  input  logic       clk_14m,
  input  logic       rst_n,
  input  logic [7:0] vram_data,
  input  logic       ld_stb,
  input  logic       pix_stb,
  input  logic       hblank_n,
  input  logic       vblank_n,
  input  logic       hsync_n,
  input  logic       vsync_n,
  input  logic       pal_we,
  input  logic [1:0] pal_addr,
  input  logic [3:0] pal_data,
  input  logic       flag_clr,
`ifdef VIDEO_SHIFTER_TESTPAT_EN
  input  logic       test_pat,
`endif
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       ce_pix,
  output logic       hblank_o,
  output logic       vblank_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       underrun,
  output logic       overrun
);

  function automatic logic [7:0] chan_level(input logic c, input logic i);
    if (c) return i ? HI_LEVEL : MID_LEVEL;
    return i ? DIM_LEVEL : 8'h00;
  endfunction

  logic [7:0] hold;
  logic       hold_valid;
  logic [7:0] shift;
  logic [1:0] count;
  logic [3:0] pal [4];

  logic       xfer_p0;
  logic       under_p0;
  logic       blank_p0;
  logic [1:0] sh_idx_p0;
  logic [1:0] pix_idx_p0;
  logic [3:0] entry_p0;

  // ---- p0: pixel selection and palette lookup from current state ----
  assign xfer_p0  = pix_stb && (count == 2'd0) && hold_valid;
  assign under_p0 = pix_stb && (count == 2'd0) && !hold_valid;
  assign blank_p0 = !hblank_n || !vblank_n;

  always_comb begin
    sh_idx_p0 = 2'd0;
    if (count != 2'd0)  sh_idx_p0 = shift[3:2];
    else if (hold_valid) sh_idx_p0 = hold[1:0];
  end

`ifdef VIDEO_SHIFTER_TESTPAT_EN
  logic [6:0] col;

  always_ff @(posedge clk_14m) begin
    if (!rst_n)       col <= 7'd0;
    else if (pix_stb) col <= hblank_n ? col + 7'd1 : 7'd0;
  end

  assign pix_idx_p0 = test_pat ? col[4:3] : sh_idx_p0;
`else
  assign pix_idx_p0 = sh_idx_p0;
`endif

  // Palette read sees the pre-write value when a write coincides with pix_stb.
  assign entry_p0 = pal[pix_idx_p0];

  always_ff @(posedge clk_14m) begin
    if (!rst_n) begin
      hold       <= 8'd0;
      hold_valid <= 1'b0;
      shift      <= 8'd0;
      count      <= 2'd0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      pal[0]     <= 4'b0000;
      pal[1]     <= 4'b1100;
      pal[2]     <= 4'b1010;
      pal[3]     <= 4'b1001;
    end else begin
      if (ld_stb)       hold_valid <= 1'b1;
      else if (xfer_p0) hold_valid <= 1'b0;
      if (ld_stb) hold <= vram_data;

      if (xfer_p0) begin
        shift <= hold;
        count <= 2'd3;
      end else if (pix_stb && count != 2'd0) begin
        shift <= shift >> 2;
        count <= count - 2'd1;
      end

      if (under_p0)      underrun <= 1'b1;
      else if (flag_clr) underrun <= 1'b0;
      if (ld_stb && hold_valid && !xfer_p0) overrun <= 1'b1;
      else if (flag_clr)                    overrun <= 1'b0;

      if (pal_we) pal[pal_addr] <= pal_data;
    end
  end

  // ---- p1: registered pixel colour and timing, updated only on pix_stb ----
  always_ff @(posedge clk_14m) begin
    if (!rst_n) begin
      r        <= BLANK_LEVEL;
      g        <= BLANK_LEVEL;
      b        <= BLANK_LEVEL;
      ce_pix   <= 1'b0;
      hblank_o <= 1'b1;
      vblank_o <= 1'b1;
      hsync_o  <= 1'b1;
      vsync_o  <= 1'b1;
    end else begin
      ce_pix <= pix_stb;
      if (pix_stb) begin
        if (blank_p0) begin
          r <= BLANK_LEVEL;
          g <= BLANK_LEVEL;
          b <= BLANK_LEVEL;
        end else begin
          r <= chan_level(entry_p0[2], entry_p0[3]);
          g <= chan_level(entry_p0[1], entry_p0[3]);
          b <= chan_level(entry_p0[0], entry_p0[3]);
        end
        hblank_o <= hblank_n;
        vblank_o <= vblank_n;
        hsync_o  <= hsync_n;
        vsync_o  <= vsync_n;
      end
    end
  end

endmodule

// File: tb/tb_video_shifter.sv
// Bench for video_shifter: queue-based pixel model checked every cycle, plus directed
// literal expectations for the main scenarios.
module tb_video_shifter;

  logic       clk_14m = 1'b0;
  logic       rst_n;
  logic [7:0] vram_data;
  logic       ld_stb, pix_stb;
  logic       hblank_n, vblank_n, hsync_n, vsync_n;
  logic       pal_we;
  logic [1:0] pal_addr;
  logic [3:0] pal_data;
  logic       flag_clr;
  logic [7:0] r, g, b;
  logic       ce_pix, hblank_o, vblank_o, hsync_o, vsync_o, underrun, overrun;

  always #5 clk_14m = ~clk_14m;

  video_shifter dut (
    .clk_14m(clk_14m), .rst_n(rst_n), .vram_data(vram_data), .ld_stb(ld_stb),
    .pix_stb(pix_stb), .hblank_n(hblank_n), .vblank_n(vblank_n), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .flag_clr(flag_clr), .r(r), .g(g), .b(b), .ce_pix(ce_pix), .hblank_o(hblank_o),
    .vblank_o(vblank_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .underrun(underrun),
    .overrun(overrun)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] lvl(input logic c, input logic i);
    case ({c, i})
      2'b00:   return 8'h00;
      2'b01:   return 8'h55;
      2'b10:   return 8'hAA;
      default: return 8'hFF;
    endcase
  endfunction

  // Model: pending pixels live in a queue; a byte is unpacked into it when the queue runs dry.
  logic [7:0] e_r, e_g, e_b;
  logic       e_ce, e_hb, e_vb, e_hs, e_vs, e_un, e_ov;
  logic [7:0] m_hold;
  bit         m_hv;
  logic [3:0] m_pal [4];
  int         pq [$];

  always @(posedge clk_14m) begin : model
    int pix;
    bit xfer, set_u, set_o;
    logic [3:0] ent;
    if (!rst_n) begin
      e_r = 8'h00; e_g = 8'h00; e_b = 8'h00; e_ce = 1'b0;
      e_hb = 1'b1; e_vb = 1'b1; e_hs = 1'b1; e_vs = 1'b1;
      e_un = 1'b0; e_ov = 1'b0;
      m_hold = 8'h00; m_hv = 1'b0; pq.delete();
      m_pal[0] = 4'b0000; m_pal[1] = 4'b1100; m_pal[2] = 4'b1010; m_pal[3] = 4'b1001;
    end else begin
      xfer = 1'b0; set_u = 1'b0; set_o = 1'b0;
      e_ce = pix_stb;
      if (pix_stb) begin
        if (pq.size() == 0) begin
          if (m_hv) begin
            xfer = 1'b1;
            for (int k = 0; k < 4; k++) pq.push_back(int'((m_hold >> (2 * k)) & 8'h03));
          end else begin
            set_u = 1'b1;
            pq.push_back(0);
          end
        end
        pix = pq.pop_front();
        ent = m_pal[pix];
        if (!hblank_n || !vblank_n) begin
          e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
        end else begin
          e_r = lvl(ent[2], ent[3]);
          e_g = lvl(ent[1], ent[3]);
          e_b = lvl(ent[0], ent[3]);
        end
        e_hb = hblank_n; e_vb = vblank_n; e_hs = hsync_n; e_vs = vsync_n;
      end
      if (ld_stb) begin
        if (m_hv && !xfer) set_o = 1'b1;
        m_hold = vram_data;
        m_hv = 1'b1;
      end else if (xfer) begin
        m_hv = 1'b0;
      end
      e_un = set_u | (e_un & ~flag_clr);
      e_ov = set_o | (e_ov & ~flag_clr);
      if (pal_we) m_pal[pal_addr] = pal_data;
    end
  end

  always @(negedge clk_14m) begin
    if (chk_en) begin
      chk("model_rgb", 32'({r, g, b}), 32'({e_r, e_g, e_b}));
      chk("model_timing", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}),
          32'({e_ce, e_hb, e_vb, e_hs, e_vs}));
      chk("model_flags", 32'({underrun, overrun}), 32'({e_un, e_ov}));
    end
  end

  task automatic cyc(input logic ld, input logic [7:0] d, input logic px, input logic clr);
    ld_stb = ld; vram_data = d; pix_stb = px; flag_clr = clr;
    @(posedge clk_14m); #1;
    ld_stb = 1'b0; pix_stb = 1'b0; flag_clr = 1'b0; pal_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vram_data = 8'h00; ld_stb = 1'b0; pix_stb = 1'b0;
    hblank_n = 1'b1; vblank_n = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
    pal_we = 1'b0; pal_addr = 2'd0; pal_data = 4'd0; flag_clr = 1'b0;
    cyc(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    chk("rst_rgb", 32'({r, g, b}), 'h000000);
    chk("rst_timing", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}), 'b01111);
    chk("rst_flags", 32'({underrun, overrun}), 'b00);

    // E4 -> entries 0,1,2,3
    cyc(1, 8'hE4, 0, 0);
    cyc(0, 8'h00, 1, 0); chk("e4_px0", 32'({r, g, b}), 'h000000); chk("e4_ce", 32'(ce_pix), 1);
    cyc(0, 8'h00, 0, 0); chk("e4_ce_low", 32'(ce_pix), 0);
    cyc(0, 8'h00, 1, 0); chk("e4_px1", 32'({r, g, b}), 'hFF5555);
    cyc(0, 8'h00, 1, 0); chk("e4_px2", 32'({r, g, b}), 'h55FF55);
    cyc(0, 8'h00, 1, 0); chk("e4_px3", 32'({r, g, b}), 'h5555FF);
    cyc(0, 8'h00, 0, 0); chk("e4_hold", 32'({r, g, b}), 'h5555FF);

    // 1B then FF with the second load on the transfer cycle
    cyc(1, 8'h1B, 0, 0);
    cyc(1, 8'hFF, 1, 0); chk("b2b_px0", 32'({r, g, b}), 'h5555FF);
    cyc(0, 8'h00, 1, 0); chk("b2b_px1", 32'({r, g, b}), 'h55FF55);
    cyc(0, 8'h00, 1, 0); chk("b2b_px2", 32'({r, g, b}), 'hFF5555);
    cyc(0, 8'h00, 1, 0); chk("b2b_px3", 32'({r, g, b}), 'h000000);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0); chk("b2b_ff", 32'({r, g, b}), 'h5555FF);
    end
    chk("b2b_flags", 32'({underrun, overrun}), 'b00);

    // Underrun and flag clear priority
    cyc(0, 8'h00, 1, 0); chk("und_rgb", 32'({r, g, b}), 'h000000);
    chk("und_set", 32'({underrun, overrun}), 'b10);
    cyc(0, 8'h00, 0, 1); chk("und_clr", 32'({underrun, overrun}), 'b00);
    cyc(0, 8'h00, 1, 1); chk("und_set_wins", 32'({underrun, overrun}), 'b10);
    cyc(0, 8'h00, 0, 1);

    // Overrun: second byte is displayed
    cyc(1, 8'h00, 0, 0);
    cyc(1, 8'hAA, 0, 0); chk("ovr_set", 32'({underrun, overrun}), 'b01);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0); chk("ovr_px", 32'({r, g, b}), 'h55FF55);
    end
    cyc(0, 8'h00, 0, 1);

    // Palette write, coincident read, blanking and sync alignment
    cyc(1, 8'hAA, 0, 0);
    pal_we = 1'b1; pal_addr = 2'd2; pal_data = 4'b0110;
    cyc(0, 8'h00, 1, 0); chk("pal_old", 32'({r, g, b}), 'h55FF55);
    cyc(0, 8'h00, 1, 0); chk("pal_new", 32'({r, g, b}), 'hAAAA00);
    hblank_n = 1'b0; hsync_n = 1'b0;
    cyc(0, 8'h00, 1, 0); hblank_n = 1'b1; hsync_n = 1'b1;
    chk("hblank_rgb", 32'({r, g, b}), 'h000000);
    chk("hblank_tim", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}), 'b10101);
    vblank_n = 1'b0; vsync_n = 1'b0;
    cyc(0, 8'h00, 1, 0); vblank_n = 1'b1; vsync_n = 1'b1;
    chk("vblank_rgb", 32'({r, g, b}), 'h000000);
    chk("vblank_tim", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}), 'b11010);
    cyc(0, 8'h00, 0, 0);
    chk("tim_hold", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}), 'b01010);
    cyc(0, 8'h00, 1, 0); chk("und_after_pal", 32'({r, g, b}), 'h000000);
    cyc(0, 8'h00, 0, 1);

    // Reset mid-byte discards buffered data and restores palette
    cyc(1, 8'hE4, 0, 0);
    cyc(1, 8'h1B, 0, 0);
    cyc(0, 8'h00, 1, 0); chk("mid_px0", 32'({r, g, b}), 'h5555FF);
    cyc(0, 8'h00, 1, 0); chk("mid_px1", 32'({r, g, b}), 'hAAAA00);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    chk("mrst_rgb", 32'({r, g, b}), 'h000000);
    chk("mrst_timing", 32'({ce_pix, hblank_o, vblank_o, hsync_o, vsync_o}), 'b01111);
    chk("mrst_flags", 32'({underrun, overrun}), 'b00);
    rst_n = 1'b1;
    cyc(0, 8'h00, 1, 0);
    chk("mrst_und", 32'({underrun, overrun}), 'b10);
    chk("mrst_und_rgb", 32'({r, g, b}), 'h000000);
    cyc(1, 8'hAA, 0, 1);
    cyc(0, 8'h00, 1, 0); chk("mrst_pal", 32'({r, g, b}), 'h55FF55);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
